// File: rtl/bp_l15_block_transducer_if.sv
// bp_l15_block_transducer_if: BP command/response and L1.5 request/return signals of one tile bridge
interface bp_l15_block_transducer_if #(
  parameter int paddr_width_p = 40,
  parameter int block_width_p = 512
) ();
  logic cmd_v_i, cmd_ready_o, cmd_write_i, cmd_nc_i;
  logic [2:0] cmd_size_i;
  logic [paddr_width_p-1:0] cmd_addr_i;
  logic [block_width_p-1:0] cmd_data_i;
  logic resp_v_o, resp_yumi_i, resp_write_o;
  logic [block_width_p-1:0] resp_data_o;
  logic transducer_l15_val, transducer_l15_nc;
  logic [4:0] transducer_l15_rqtype;
  logic [2:0] transducer_l15_size;
  logic [paddr_width_p-1:0] transducer_l15_address;
  logic [63:0] transducer_l15_data;
  logic l15_transducer_ack, l15_transducer_val, transducer_l15_req_ack;
  logic [3:0] l15_transducer_returntype;
  logic [63:0] l15_transducer_data_0, l15_transducer_data_1;
  modport slave (
    input  cmd_v_i, cmd_write_i, cmd_nc_i, cmd_size_i, cmd_addr_i, cmd_data_i, resp_yumi_i,
    input  l15_transducer_ack, l15_transducer_val, l15_transducer_returntype,
    input  l15_transducer_data_0, l15_transducer_data_1,
    output cmd_ready_o, resp_v_o, resp_write_o, resp_data_o,
    output transducer_l15_val, transducer_l15_nc, transducer_l15_rqtype, transducer_l15_size,
    output transducer_l15_address, transducer_l15_data, transducer_l15_req_ack
  );
  modport master (
    output cmd_v_i, cmd_write_i, cmd_nc_i, cmd_size_i, cmd_addr_i, cmd_data_i, resp_yumi_i,
    output l15_transducer_ack, l15_transducer_val, l15_transducer_returntype,
    output l15_transducer_data_0, l15_transducer_data_1,
    input  cmd_ready_o, resp_v_o, resp_write_o, resp_data_o,
    input  transducer_l15_val, transducer_l15_nc, transducer_l15_rqtype, transducer_l15_size,
    input  transducer_l15_address, transducer_l15_data, transducer_l15_req_ack
  );
endinterface

// File: rtl/bp_l15_block_transducer.sv
// bp_l15_block_transducer: splits one block-granular BP memory command into L1.5 beats
// (16B loads, 8B stores) and gathers the returns into a single block-wide response.
module bp_l15_block_transducer #(
  parameter int paddr_width_p = 40,
  parameter int block_width_p = 512,
  localparam int lg_block_bytes_lp = $clog2(block_width_p/8),
  localparam int cnt_width_lp = $clog2(block_width_p/64)+1
) (
  input logic clk_i,
  input logic reset_i,
  bp_l15_block_transducer_if.slave io
);
  typedef enum logic [1:0] {IDLE, SEND, WAIT, RESP} state_e;
  state_e state_q, state_d;
  logic write_q, write_d, nc_q, nc_d, match;
  logic [2:0] size_q, size_d, cmd_size, cmd_lsz;
  logic [paddr_width_p-1:0] base_q, base_d;
  logic [block_width_p-1:0] data_q, data_d, buf_q, buf_d;
  logic [cnt_width_lp-1:0] cnt_q, cnt_d, last_cnt;
  logic [63:0] ret_word, ret_mask;
  assign cmd_size = io.cmd_size_i > 3'(lg_block_bytes_lp) ? 3'(lg_block_bytes_lp) : io.cmd_size_i;
  assign cmd_lsz = io.cmd_write_i ? (cmd_size > 3'd3 ? 3'd3 : cmd_size)
                                  : (cmd_size > 3'd4 ? 3'd4 : cmd_size);
  assign last_cnt = write_q ? (size_q > 3'd3 ? cnt_width_lp'((1 << (size_q - 3'd3)) - 1) : '0)
                            : (size_q > 3'd4 ? cnt_width_lp'((1 << (size_q - 3'd4)) - 1) : '0);
  // A return is ours only while a request is in flight: in WAIT, or in the cycle SEND is acked.
  assign match = io.l15_transducer_val && io.l15_transducer_returntype == {1'b0, write_q, 2'b00}
              && (state_q == WAIT || (state_q == SEND && io.l15_transducer_ack));
  assign ret_word = (base_q[3] ? io.l15_transducer_data_1 : io.l15_transducer_data_0) >> {base_q[2:0], 3'b000};
  assign ret_mask = size_q == 3'd0 ? 64'hff : size_q == 3'd1 ? 64'hffff
                  : size_q == 3'd2 ? 64'hffff_ffff : '1;
  assign io.cmd_ready_o = state_q == IDLE;
  assign io.resp_v_o = state_q == RESP;
  assign io.resp_write_o = write_q;
  assign io.resp_data_o = buf_q;
  assign io.transducer_l15_val = state_q == SEND;
  assign io.transducer_l15_nc = nc_q;
  assign io.transducer_l15_rqtype = {4'b0000, write_q};
  assign io.transducer_l15_size = write_q ? (size_q > 3'd3 ? 3'b011 : size_q)
                                          : (size_q > 3'd4 ? 3'b111 : size_q == 3'd4 ? 3'b111 : size_q);
  assign io.transducer_l15_address = base_q + (paddr_width_p'(cnt_q) << (write_q ? 3 : 4));
  assign io.transducer_l15_data = size_q > 3'd2 ? 64'(data_q >> {cnt_q, 6'b0})
                                : size_q == 3'd2 ? {2{data_q[31:0]}}
                                : size_q == 3'd1 ? {4{data_q[15:0]}} : {8{data_q[7:0]}};
  assign io.transducer_l15_req_ack = io.l15_transducer_val;
  always_comb begin
    state_d = state_q;
    write_d = write_q;
    nc_d = nc_q;
    size_d = size_q;
    base_d = base_q;
    data_d = data_q;
    buf_d = buf_q;
    cnt_d = cnt_q;
    if (state_q == IDLE && io.cmd_v_i) begin
      state_d = SEND;
      write_d = io.cmd_write_i;
      nc_d = io.cmd_nc_i;
      size_d = cmd_size;
      base_d = io.cmd_addr_i & ~((paddr_width_p'(1) << cmd_lsz) - paddr_width_p'(1));
      data_d = io.cmd_data_i;
    end
    if (state_q == SEND && io.l15_transducer_ack) state_d = WAIT;
    if (match) begin
      cnt_d = cnt_q + 1'b1;
      state_d = cnt_q == last_cnt ? RESP : SEND;
      if (!write_q)
        buf_d = size_q > 3'd3
              ? buf_q | (block_width_p'({io.l15_transducer_data_1, io.l15_transducer_data_0}) << {cnt_q, 7'b0})
              : block_width_p'(ret_word & ret_mask);
    end
    if (state_q == RESP && io.resp_yumi_i) begin
      state_d = IDLE;
      buf_d = '0;
      cnt_d = '0;
    end
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      nc_q <= 1'b0;
      size_q <= '0;
      base_q <= '0;
      data_q <= '0;
      buf_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      nc_q <= nc_d;
      size_q <= size_d;
      base_q <= base_d;
      data_q <= data_d;
      buf_q <= buf_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_bp_l15_block_transducer.sv
// tb_bp_l15_block_transducer: directed commands against a byte-level model of the beat split and response gather
module tb_bp_l15_block_transducer;
  localparam int pw = 40, bw = 512, lg = 6;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  bp_l15_block_transducer_if #(.paddr_width_p(pw), .block_width_p(bw)) io ();
  bp_l15_block_transducer #(.paddr_width_p(pw), .block_width_p(bw)) dut (.clk_i(clk), .reset_i(rst), .io(io));
  int total = 0, bad = 0;
  logic [pw-1:0] q_addr[$];
  logic [2:0] q_size[$];
  logic [63:0] q_data[$];
  logic q_write = 1'b0, q_nc = 1'b0;
  logic [63:0] rd0[16], rd1[16];
  logic lit_resp_en = 1'b0, lit_data_en = 1'b0;
  logic [bw-1:0] lit_resp, sd;
  logic [63:0] lit_data;
  task automatic chk(input string name, input logic [bw-1:0] act, input logic [bw-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask
  function automatic logic [63:0] rep(input logic [63:0] d, input int es);
    logic [63:0] r;
    r = '0;
    for (int j = 0; j < 8; j++) r |= 64'(8'(d >> (8 * (j % (1 << es))))) << (8 * j);
    return r;
  endfunction
  function automatic logic [bw-1:0] exp_load(input int es, input logic [pw-1:0] addr, input int n);
    logic [bw-1:0] r;
    int off;
    r = '0;
    if (es >= 4) for (int k = 0; k < n; k++) r |= bw'({rd1[k], rd0[k]}) << (128 * k);
    else for (int i = 0; i < (1 << es); i++) begin
      off = int'(addr[3:0]) + i;
      r |= bw'(off < 8 ? 8'(rd0[0] >> (8 * off)) : 8'(rd1[0] >> (8 * (off - 8)))) << (8 * i);
    end
    return r;
  endfunction
  task automatic model_cmd(input logic w, input logic nc, input int size, input logic [pw-1:0] addr,
                           input logic [bw-1:0] data, output int n);
    int lb, es, al;
    logic [pw-1:0] base;
    lb = w ? 3 : 4;
    es = size > lg ? lg : size;
    al = es < lb ? es : lb;
    n = es <= lb ? 1 : 1 << (es - lb);
    base = addr & ~((pw'(1) << al) - pw'(1));
    q_write = w;
    q_nc = nc;
    for (int k = 0; k < n; k++) begin
      q_addr.push_back(base + pw'(k * (1 << lb)));
      q_size.push_back(al == 4 ? 3'b111 : 3'(al));
      q_data.push_back(es >= 3 ? 64'(data >> (64 * k)) : rep(data[63:0], es));
    end
  endtask
  always @(negedge clk) begin
    chk("req_ack", bw'(io.transducer_l15_req_ack), bw'(io.l15_transducer_val));
    if (io.transducer_l15_val) begin
      if (q_addr.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_req addr=%0h required=no request", io.transducer_l15_address);
      end else begin
        chk("req_addr", bw'(io.transducer_l15_address), bw'(q_addr[0]));
        chk("req_size", bw'(io.transducer_l15_size), bw'(q_size[0]));
        chk("req_type", bw'(io.transducer_l15_rqtype), bw'({4'b0000, q_write}));
        chk("req_nc", bw'(io.transducer_l15_nc), bw'(q_nc));
        if (q_write) chk("req_data", bw'(io.transducer_l15_data), bw'(q_data[0]));
      end
    end
  end
  task automatic set_ret(input int k, input logic w);
    io.l15_transducer_val = 1'b1;
    io.l15_transducer_returntype = w ? 4'b0100 : 4'b0000;
    io.l15_transducer_data_0 = rd0[k];
    io.l15_transducer_data_1 = rd1[k];
  endtask
  task automatic send_cmd(input logic w, input logic nc, input int size, input logic [pw-1:0] addr, input logic [bw-1:0] data);
    @(negedge clk);
    chk("cmd_ready_idle", bw'(io.cmd_ready_o), bw'(1));
    @(posedge clk); #1;
    io.cmd_v_i = 1'b1;
    io.cmd_write_i = w;
    io.cmd_nc_i = nc;
    io.cmd_size_i = 3'(size);
    io.cmd_addr_i = addr;
    io.cmd_data_i = data;
    @(posedge clk); #1;
    io.cmd_v_i = 1'b0;
    @(negedge clk);
    chk("cmd_ready_busy", bw'(io.cmd_ready_o), bw'(0));
  endtask
  task automatic wait_val();
    int t = 0;
    while (!io.transducer_l15_val && t < 50) begin @(negedge clk); t++; end
    chk("req_seen", bw'(io.transducer_l15_val), bw'(1));
  endtask
  task automatic do_beat(input int k, input logic w, input int hold, input logic foreign, input logic same);
    wait_val();
    if (k == 0 && lit_data_en) chk("lit_req_data", bw'(io.transducer_l15_data), bw'(lit_data));
    repeat (hold) begin @(negedge clk); chk("val_hold", bw'(io.transducer_l15_val), bw'(1)); end
    @(posedge clk); #1;
    io.l15_transducer_ack = 1'b1;
    if (same) set_ret(k, w);
    @(posedge clk); #1;
    io.l15_transducer_ack = 1'b0;
    io.l15_transducer_val = 1'b0;
    if (q_addr.size() != 0) begin
      void'(q_addr.pop_front());
      void'(q_size.pop_front());
      void'(q_data.pop_front());
    end
    if (!same) begin
      @(negedge clk);
      chk("one_outstanding", bw'(io.transducer_l15_val), bw'(0));
      if (foreign) begin
        @(posedge clk); #1;
        io.l15_transducer_val = 1'b1;
        io.l15_transducer_returntype = 4'b0011;
        io.l15_transducer_data_0 = 64'hdead_beef_dead_beef;
        io.l15_transducer_data_1 = 64'hfeed_face_feed_face;
        @(posedge clk); #1;
        io.l15_transducer_val = 1'b0;
        @(negedge clk);
        chk("foreign_ignored", bw'(io.transducer_l15_val | io.resp_v_o), bw'(0));
      end
      @(posedge clk); #1;
      set_ret(k, w);
      @(posedge clk); #1;
      io.l15_transducer_val = 1'b0;
    end
  endtask
  task automatic run_cmd(input logic w, input logic nc, input int size, input logic [pw-1:0] addr,
                         input logic [bw-1:0] data, input int hold, input logic foreign, input logic same);
    int n, t;
    logic [bw-1:0] exp;
    model_cmd(w, nc, size, addr, data, n);
    exp = w ? '0 : exp_load(size > lg ? lg : size, addr, n);
    send_cmd(w, nc, size, addr, data);
    for (int k = 0; k < n; k++) do_beat(k, w, hold, foreign, same);
    t = 0;
    while (!io.resp_v_o && t < 50) begin @(negedge clk); t++; end
    chk("resp_seen", bw'(io.resp_v_o), bw'(1));
    chk("resp_data", io.resp_data_o, exp);
    chk("resp_write", bw'(io.resp_write_o), bw'(w));
    if (lit_resp_en) chk("lit_resp", io.resp_data_o, lit_resp);
    @(posedge clk); #1;
    io.resp_yumi_i = 1'b1;
    @(posedge clk); #1;
    io.resp_yumi_i = 1'b0;
    @(negedge clk);
    chk("resp_pulse", bw'(io.resp_v_o), bw'(0));
    lit_resp_en = 1'b0;
    lit_data_en = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    io.cmd_v_i = 1'b0; io.cmd_write_i = 1'b0; io.cmd_nc_i = 1'b0; io.cmd_size_i = '0;
    io.cmd_addr_i = '0; io.cmd_data_i = '0; io.resp_yumi_i = 1'b0;
    io.l15_transducer_ack = 1'b0; io.l15_transducer_val = 1'b0; io.l15_transducer_returntype = '0;
    io.l15_transducer_data_0 = '0; io.l15_transducer_data_1 = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", bw'(io.cmd_ready_o), bw'(1));
    chk("rst_resp_v", bw'(io.resp_v_o), bw'(0));
    chk("rst_l15_val", bw'(io.transducer_l15_val), bw'(0));
    chk("rst_resp_data", io.resp_data_o, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin rd0[k] = 64'(2 * k); rd1[k] = 64'(2 * k + 1); end
    lit_resp_en = 1'b1;
    lit_resp = 512'h0000000000000007_0000000000000006_0000000000000005_0000000000000004_0000000000000003_0000000000000002_0000000000000001_0000000000000000;
    run_cmd(1'b0, 1'b0, 6, 40'h1000, '0, 0, 1'b0, 1'b0);
    sd = '0;
    for (int i = 0; i < 8; i++) sd |= bw'({32'(32'hC0DE0000 + i), 32'(32'h11111111 * i)}) << (64 * i);
    run_cmd(1'b1, 1'b0, 6, 40'h2000, sd, 0, 1'b0, 1'b1);
    rd0[0] = 64'h1122334455667788; rd1[0] = 64'h99aabbccddeeff00;
    lit_resp_en = 1'b1; lit_resp = 512'h1122;
    run_cmd(1'b0, 1'b1, 1, 40'h3006, '0, 0, 1'b0, 1'b0);
    lit_data_en = 1'b1; lit_data = 64'hABABABABABABABAB;
    run_cmd(1'b1, 1'b0, 0, 40'h4003, 512'hAB, 0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin rd0[k] = 64'h5000_0000_0000_0000 + 64'(k); rd1[k] = 64'h5100_0000_0000_0000 + 64'(k); end
    run_cmd(1'b0, 1'b0, 6, 40'h5000, '0, 5, 1'b1, 1'b0);
    rd0[0] = 64'h0123456789abcdef; rd1[0] = 64'h8877665544332211;
    lit_resp_en = 1'b1; lit_resp = 512'h88776655;
    run_cmd(1'b0, 1'b0, 2, 40'h600C, '0, 1, 1'b0, 1'b0);
    rd0[0] = 64'h7777_0000_1111_2222; rd1[0] = 64'h7777_3333_4444_5555;
    run_cmd(1'b0, 1'b0, 4, 40'h7010, '0, 0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin rd0[k] = 64'(k * 64'h0101) ^ 64'h8; rd1[k] = ~64'(k); end
    run_cmd(1'b0, 1'b1, 7, 40'h8000, '0, 0, 1'b0, 1'b0);
    run_cmd(1'b1, 1'b0, 5, 40'h9020, ~sd, 2, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin rd0[k] = 64'hA0 + 64'(k); rd1[k] = 64'hB0 + 64'(k); end
    model_cmd(1'b0, 1'b0, 6, 40'hA000, '0, n);
    send_cmd(1'b0, 1'b0, 6, 40'hA000, '0);
    do_beat(0, 1'b0, 0, 1'b0, 1'b0);
    wait_val();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q_addr.delete(); q_size.delete(); q_data.delete();
    @(negedge clk);
    chk("abort_ready", bw'(io.cmd_ready_o), bw'(1));
    chk("abort_val", bw'(io.transducer_l15_val), bw'(0));
    @(posedge clk); #1;
    set_ret(1, 1'b0);
    @(posedge clk); #1;
    io.l15_transducer_val = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("late_ret_dropped", bw'(io.resp_v_o | io.transducer_l15_val), bw'(0));
    end
    for (int k = 0; k < 4; k++) begin rd0[k] = 64'hC0 + 64'(k); rd1[k] = 64'hD0 + 64'(k); end
    run_cmd(1'b0, 1'b0, 6, 40'hB040, '0, 0, 1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
